ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- EX/WB pipeline register plus the architectural register file for the 8-bit pipelined core.
- Captures the ALU result, destination register and write enable leaving EX.
- Drives the WB-side rd/regwrite/data toward the forwarding unit.
- Commits results into an 8-entry register file with two combinational read ports feeding ID/EX.

Parameters:
- DATA_W, 8, datapath width
- REG_ADDR_W, 3, register address width; NUM_REGS = 2**REG_ADDR_W
- CNT_W, 16, width of the retire counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold WB register contents; no commit this cycle
- flush  in  1  replace incoming EX instruction with a bubble
- ex_valid  in  1  EX holds a real instruction
- ex_rd  in  REG_ADDR_W  EX destination register
- ex_regwrite  in  1  EX instruction writes rd
- ex_result  in  DATA_W  ALU result from EX
- wb_valid  out  1  WB register holds a real instruction
- wb_rd  out  REG_ADDR_W  WB destination (to forwarding unit)
- wb_regwrite  out  1  wb_valid AND captured regwrite (to forwarding unit)
- wb_data  out  DATA_W  WB result (forwarding mux source)
- rs1_addr  in  REG_ADDR_W  read port 1 address
- rs2_addr  in  REG_ADDR_W  read port 2 address
- rs1_data  out  DATA_W  read port 1 data, combinational
- rs2_data  out  DATA_W  read port 2 data, combinational
- retire_count  out  CNT_W  instructions retired since reset, saturating

Behaviour:
- Reset (reset=1 at a clk edge): wb_valid, wb_rd, wb_regwrite, wb_data, retire_count and all NUM_REGS registers clear to 0. Reset overrides stall and flush.
- WB register update, evaluated at each clk edge in priority order:
  - flush=1: wb_valid=0 and wb_regwrite=0; wb_rd/wb_data don't-care, implemented as 0.
  - else stall=1: all WB fields hold.
  - else: capture ex_valid, ex_rd, ex_regwrite, ex_result. wb_regwrite is latched as ex_valid & ex_regwrite.
- Latency: exactly one cycle from EX inputs to WB outputs.
- Commit condition: commit = wb_valid & ~stall, evaluated in the cycle before the edge.
  - If commit & wb_regwrite: regs[wb_rd] <= wb_data at that edge.
  - The instruction currently in WB still commits when flush=1. Flush kills only the incoming EX instruction.
  - Under stall, the commit is deferred to the first unstalled cycle, so there is exactly one write per instruction.
- Retire counter: increments by 1 on every commit, including instructions with wb_regwrite=0. It saturates at 2**CNT_W-1 and never wraps.
- Read ports:
  - Purely combinational from the register array and rsX_addr.
  - Both ports may address the same register.
  - rs1_addr == rs2_addr returns identical data on both ports.
- All register addresses, including 0, are writable; there is no hardwired zero register.
- Mid-operation reset discards the WB instruction without committing it.

Optional Feature:
- Macro: WB_RF_BYPASS_EN.
- Defined: read ports write-through. If commit & wb_regwrite and rsX_addr == wb_rd, rsX_data = wb_data in the same cycle. Otherwise array content is returned.
- Undefined: read ports return array content only. The new value is visible the cycle after commit, and the forwarding unit covers the gap.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and REG_ADDR_W constants
  - typedefs data_t and reg_addr_t
  - struct wb_bundle_t {valid, rd, regwrite, data}, used as the WB register type
- One sub-module, reg_file:
  - NUM_REGS x DATA_W array, synchronous reset
  - one write port (we, waddr, wdata)
  - two combinational read ports
  - the optional bypass mux
- ex_wb_stage instantiates reg_file and owns the WB register, commit logic and retire counter.

Test Plan:
- Reset then idle: after reset, all outputs 0; rs1_addr=5 and rs2_addr=7 read 0; retire_count=0 over 10 cycles.
- Basic writeback: ex_valid=1, ex_rd=3, ex_regwrite=1, ex_result=8'h2A.
  - Next cycle: wb_rd=3, wb_regwrite=1, wb_data=8'h2A.
  - Following cycle: rs1_addr=3 reads 8'h2A; retire_count=1.
- Stall hold: with WB holding rd=2/data=8'h11, assert stall for 3 cycles.
  - WB outputs stay unchanged; regs[2] remains old; retire_count unchanged.
  - On release, regs[2]=8'h11 and retire_count increments by exactly 1.
- Flush vs commit: WB holds rd=4/data=8'h55, and flush=1 while EX presents rd=6/data=8'h77.
  - regs[4]=8'h55 commits; wb_valid=0 next cycle; regs[6] unchanged.
  - Flush with stall simultaneously: flush wins.
- Bypass: same-cycle commit of rd=1/data=8'h9C with rs2_addr=1.
  - WB_RF_BYPASS_EN defined: rs2_data=8'h9C that cycle.
  - Undefined: rs2_data shows the old value, then 8'h9C the next cycle.
- Counter saturation (CNT_W=4): 20 back-to-back valid instructions, regwrite=0 on some.
  - retire_count reaches 15 and holds there.
  - Registers are written only by the instructions with regwrite=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the 8-bit pipelined core.
package cpu_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Contents of the EX/WB pipeline register.
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      regwrite;
        data_t     data;
    } wb_bundle_t;

endpackage

// File: rtl/ex_wb_stage_reg_file.sv
// Architectural register file: one write port, two combinational read ports.
// Optional write-through on the read ports when WB_RF_BYPASS_EN is defined.
module reg_file #(
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
`ifdef WB_RF_BYPASS_EN
        // Same-cycle write-through of the value being committed.
        if (we && (raddr1 == waddr)) rdata1 = wdata;
        if (we && (raddr2 == waddr)) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register, commit logic, saturating retire counter and register file.
// Read-port write-through is enabled by defining WB_RF_BYPASS_EN.
module ex_wb_stage #(
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic [DATA_W-1:0]     ex_result,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_regwrite,
    output logic [DATA_W-1:0]     wb_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    output logic [CNT_W-1:0]      retire_count
);

    import cpu_pkg::*;

    wb_bundle_t       wb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             commit;
    logic             rf_we;

    // The WB instruction commits whenever it is not stalled, even while flush
    // kills the incoming EX instruction.
    assign commit = wb_q.valid & ~stall;
    assign rf_we  = commit & wb_q.regwrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else if (flush) begin
            wb_q <= '0;
        end else if (!stall) begin
            wb_q <= '{valid:    ex_valid,
                      rd:       ex_rd,
                      regwrite: ex_valid & ex_regwrite,
                      data:     ex_result};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (commit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign wb_valid     = wb_q.valid;
    assign wb_rd        = wb_q.rd;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_data      = wb_q.data;
    assign retire_count = cnt_q;

    reg_file #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (wb_q.rd),
        .wdata  (wb_q.data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage: directed scenarios followed by random traffic,
// checked against a behavioural register-file/pipeline model.
module tb_ex_wb_stage;

    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1, stall = 1'b0, flush = 1'b0;
    logic          ex_valid = 1'b0, ex_regwrite = 1'b0;
    logic [2:0]    ex_rd = '0, rs1_addr = '0, rs2_addr = '0;
    logic [7:0]    ex_result = '0;
    logic          wb_valid, wb_regwrite;
    logic [2:0]    wb_rd;
    logic [7:0]    wb_data, rs1_data, rs2_data;
    logic [CW-1:0] retire_count;

    always #5 clk = ~clk;

    ex_wb_stage #(.DATA_W(8), .REG_ADDR_W(3), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_result(ex_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .retire_count(retire_count)
    );

    typedef struct {
        logic [2:0] rd;
        logic       rw;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model: architectural registers, retire count, and the WB slot.
    logic [7:0] mregs [8] = '{default: 8'h00};
    int         mcnt = 0;
    logic       mv = 1'b0, mrw = 1'b0;
    logic [2:0] mrd = '0;
    logic [7:0] md = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
`ifdef WB_RF_BYPASS_EN
        if (mv && !stall && mrw && (a == mrd)) return md;
`endif
        return mregs[a];
    endfunction

    task automatic apply(input logic r, input logic s, input logic f, input logic v,
                         input logic [2:0] rd, input logic rw, input logic [7:0] d,
                         input logic [2:0] a1, input logic [2:0] a2);
        reset = r; stall = s; flush = f;
        ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_result = d;
        rs1_addr = a1; rs2_addr = a2;
        @(negedge clk);
        chk("wb_valid", 32'(wb_valid), 32'(mv));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(mrw));
        if (mv) begin
            chk("wb_rd", 32'(wb_rd), 32'(mrd));
            chk("wb_data", 32'(wb_data), 32'(md));
        end
        chk("rs1_data", 32'(rs1_data), 32'(exp_rd(rs1_addr)));
        chk("rs2_data", 32'(rs2_data), 32'(exp_rd(rs2_addr)));
        chk("retire_count", 32'(retire_count), mcnt);
    endtask

    // Advance the model across the coming edge, then move to just after it.
    task automatic tick();
        if (reset) begin
            mregs = '{default: 8'h00};
            mcnt = 0; mv = 0; mrw = 0; mrd = '0; md = '0;
            q.delete();
        end else begin
            if (mv && !stall) begin
                if (mrw) mregs[mrd] = md;
                if (mcnt < CNT_MAX) mcnt++;
            end
            if (flush) begin
                if (mv && stall) q.delete(0);
                mv = 0; mrw = 0; mrd = '0; md = '0;
            end else if (!stall) begin
                mv = ex_valid; mrw = ex_valid & ex_regwrite; mrd = ex_rd; md = ex_result;
                if (ex_valid) q.push_back('{ex_rd, ex_valid & ex_regwrite, ex_result});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                       input logic [2:0] rd, input logic rw, input logic [7:0] d,
                       input logic [2:0] a1, input logic [2:0] a2);
        apply(r, s, f, v, rd, rw, d, a1, a2);
        tick();
    endtask

    // Monitor: every commit presented by the DUT must match the oldest issued instruction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && wb_valid && !stall) begin
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL sb_unexpected: commit rd=%0d data=%0h, expected none", wb_rd, wb_data);
            end else begin
                e = q.pop_front();
                chk("sb_rd", 32'(wb_rd), 32'(e.rd));
                chk("sb_regwrite", 32'(wb_regwrite), 32'(e.rw));
                chk("sb_data", 32'(wb_data), 32'(e.d));
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 0, 0, 5, 7);
        apply(0, 0, 0, 0, 0, 0, 0, 5, 7);
        chk("idle_rs1", 32'(rs1_data), 0);
        chk("idle_rs2", 32'(rs2_data), 0);
        chk("idle_cnt", 32'(retire_count), 0);
        tick();

        cyc(0, 0, 0, 1, 3, 1, 8'h2A, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("basic_wb_rd", 32'(wb_rd), 3);
        chk("basic_wb_regwrite", 32'(wb_regwrite), 1);
        chk("basic_wb_data", 32'(wb_data), 32'h2A);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("basic_rf", 32'(rs1_data), 32'h2A);
        chk("basic_cnt", 32'(retire_count), 1);
        tick();

        cyc(0, 0, 0, 1, 2, 1, 8'h11, 2, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 1, 5, 1, 8'hEE, 2, 0);
            chk("stall_wb_rd", 32'(wb_rd), 2);
            chk("stall_wb_data", 32'(wb_data), 32'h11);
            chk("stall_rf_old", 32'(rs1_data), 0);
            chk("stall_cnt", 32'(retire_count), 1);
            tick();
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 2, 0);
        chk("stall_release_rf", 32'(rs1_data), 32'h11);
        chk("stall_release_cnt", 32'(retire_count), 2);
        tick();

        cyc(0, 0, 0, 1, 4, 1, 8'h55, 0, 0);
        cyc(0, 0, 1, 1, 6, 1, 8'h77, 4, 6);
        apply(0, 0, 0, 0, 0, 0, 0, 4, 6);
        chk("flush_wb_valid", 32'(wb_valid), 0);
        chk("flush_commit", 32'(rs1_data), 32'h55);
        chk("flush_killed", 32'(rs2_data), 0);
        chk("flush_cnt", 32'(retire_count), 3);
        tick();
        cyc(0, 0, 0, 1, 5, 1, 8'h33, 5, 0);
        cyc(0, 1, 1, 1, 7, 1, 8'h44, 5, 7);
        apply(0, 0, 0, 0, 0, 0, 0, 5, 7);
        chk("flush_stall_wb_valid", 32'(wb_valid), 0);
        chk("flush_stall_rf5", 32'(rs1_data), 0);
        chk("flush_stall_rf7", 32'(rs2_data), 0);
        chk("flush_stall_cnt", 32'(retire_count), 3);
        tick();

        cyc(0, 0, 0, 1, 1, 1, 8'h9C, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef WB_RF_BYPASS_EN
        chk("bypass_same_cycle", 32'(rs2_data), 32'h9C);
`else
        chk("bypass_old_value", 32'(rs2_data), 0);
`endif
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("bypass_next_cycle", 32'(rs2_data), 32'h9C);
        chk("bypass_cnt", 32'(retire_count), 4);
        tick();

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 0, 1, 3'(i % 8), (i % 3) != 0, 8'($urandom), 3'($urandom), 3'($urandom));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_cnt", 32'(retire_count), 15);
        tick();
        for (int a = 0; a < 8; a++) cyc(0, 0, 0, 0, 0, 0, 0, 3'(a), 3'(a));

        repeat (400)
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 80, 3'($urandom), 1'($urandom), 8'($urandom),
                3'($urandom), 3'($urandom));
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 3'($urandom), 3'($urandom));
        chk("sb_drain", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
